// File: rtl/cpu_trace_emitter_if.sv
// Record-in / char-out bundle between the write-back monitor, the trace emitter
// and the trace checker. The emitter uses the slave view; the environment uses master.
interface cpu_trace_emitter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_mem;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        frame_done;

  modport master (
    output in_valid, in_is_mem, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    input  in_ready, char_out, char_valid, frame_done
  );

  modport slave (
    input  in_valid, in_is_mem, in_time, in_pc, in_reg, in_addr, in_data, char_ready,
    output in_ready, char_out, char_valid, frame_done
  );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one latched write-back record into an ASCII trace line, one char per
// char_valid&char_ready transfer: "^T@PPPPPPPP: $R <= DDDDDDDD#" or "... *AAAAAAAA ...".
module cpu_trace_emitter #(
  parameter bit HEX_UPPER   = 1'b0,
  parameter bit EMIT_SPACES = 1'b1
) (
  input logic              clk,
  input logic              reset,
  cpu_trace_emitter_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TAG,
    S_OPND, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  dig_q, dig_d;
  logic        is_mem_q;
  logic [13:0] time_q;
  logic [31:0] pc_q;
  logic [4:0]  reg_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        accept;
  logic        fire;
  logic        last_dig;
  logic [2:0]  t_ndig;
  logic [2:0]  r_ndig;
  logic [3:0]  t_digit;
  logic [3:0]  r_digit;
  logic [7:0]  char_c;

  function automatic logic [3:0] dec_digit(input logic [13:0] v, input logic [1:0] k);
    logic [13:0] q;
    case (k)
      2'd0:    q = v;
      2'd1:    q = v / 14'd10;
      2'd2:    q = v / 14'd100;
      default: q = v / 14'd1000;
    endcase
    return 4'(q % 14'd10);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign accept         = (state_q == S_IDLE) && bus.in_valid;
  assign fire           = (state_q != S_IDLE) && bus.char_ready;
  assign last_dig       = (dig_q == 3'd0);
  assign t_ndig         = (time_q >= 14'd1000) ? 3'd4 :
                          (time_q >= 14'd100)  ? 3'd3 :
                          (time_q >= 14'd10)   ? 3'd2 : 3'd1;
  assign r_ndig         = (reg_q >= 5'd10) ? 3'd2 : 3'd1;
  assign t_digit        = dec_digit(time_q, dig_q[1:0]);
  assign r_digit        = dec_digit({9'd0, reg_q}, dig_q[1:0]);

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.char_valid = (state_q != S_IDLE);
  assign bus.char_out   = char_c;
  assign bus.frame_done = (state_q == S_HASH) && bus.char_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dig_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
    end
  end

  // NOTE: record registers carry no reset; they are only read after an accept reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_mem_q <= bus.in_is_mem;
      time_q   <= (bus.in_time > 14'd9999) ? 14'd9999 : bus.in_time;
      pc_q     <= bus.in_pc;
      reg_q    <= bus.in_reg;
      addr_q   <= bus.in_addr;
      data_q   <= bus.in_data;
    end
  end

  // Digit fields stay in their state, counting dig_q down to 0, before moving on.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    char_c  = 8'h00;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CARET;
      S_CARET: begin
        char_c = 8'h5e;
        if (fire) begin state_d = S_TIME; dig_d = t_ndig - 3'd1; end
      end
      S_TIME: begin
        char_c = 8'h30 + {4'h0, t_digit};
        if (fire) begin
          if (last_dig) state_d = S_AT;
          else          dig_d   = dig_q - 3'd1;
        end
      end
      S_AT: begin
        char_c = 8'h40;
        if (fire) begin state_d = S_PC; dig_d = 3'd7; end
      end
      S_PC: begin
        char_c = hex_char(pc_q[{dig_q, 2'b00} +: 4]);
        if (fire) begin
          if (last_dig) state_d = S_COLON;
          else          dig_d   = dig_q - 3'd1;
        end
      end
      S_COLON: begin
        char_c = 8'h3a;
        if (fire) state_d = EMIT_SPACES ? S_SP1 : S_TAG;
      end
      S_SP1: begin
        char_c = 8'h20;
        if (fire) state_d = S_TAG;
      end
      S_TAG: begin
        char_c = is_mem_q ? 8'h2a : 8'h24;
        if (fire) begin
          state_d = S_OPND;
          dig_d   = is_mem_q ? 3'd7 : r_ndig - 3'd1;
        end
      end
      S_OPND: begin
        char_c = is_mem_q ? hex_char(addr_q[{dig_q, 2'b00} +: 4]) : 8'h30 + {4'h0, r_digit};
        if (fire) begin
          if (last_dig) state_d = EMIT_SPACES ? S_SP2 : S_LT;
          else          dig_d   = dig_q - 3'd1;
        end
      end
      S_SP2: begin
        char_c = 8'h20;
        if (fire) state_d = S_LT;
      end
      S_LT: begin
        char_c = 8'h3c;
        if (fire) state_d = S_EQ;
      end
      S_EQ: begin
        char_c = 8'h3d;
        if (fire) begin
          state_d = EMIT_SPACES ? S_SP3 : S_DATA;
          dig_d   = 3'd7;
        end
      end
      S_SP3: begin
        char_c = 8'h20;
        if (fire) begin state_d = S_DATA; dig_d = 3'd7; end
      end
      S_DATA: begin
        char_c = hex_char(data_q[{dig_q, 2'b00} +: 4]);
        if (fire) begin
          if (last_dig) state_d = S_HASH;
          else          dig_d   = dig_q - 3'd1;
        end
      end
      S_HASH: begin
        char_c = 8'h23;
        if (fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: two instances (lowercase with spaces, and
// uppercase without spaces) share stimulus; sel picks which one a frame targets.
module tb_cpu_trace_emitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_trace_emitter_if if0();
  cpu_trace_emitter_if if1();

  cpu_trace_emitter #(.HEX_UPPER(1'b0), .EMIT_SPACES(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  cpu_trace_emitter #(.HEX_UPPER(1'b1), .EMIT_SPACES(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  logic        sel = 1'b0;
  logic        v_valid = 1'b0;
  logic        v_is_mem = 1'b0;
  logic [13:0] v_time = '0;
  logic [31:0] v_pc = '0;
  logic [4:0]  v_reg = '0;
  logic [31:0] v_addr = '0;
  logic [31:0] v_data = '0;
  logic        cr = 1'b1;

  assign if0.in_valid   = v_valid & ~sel;
  assign if1.in_valid   = v_valid & sel;
  assign if0.in_is_mem  = v_is_mem;  assign if1.in_is_mem  = v_is_mem;
  assign if0.in_time    = v_time;    assign if1.in_time    = v_time;
  assign if0.in_pc      = v_pc;      assign if1.in_pc      = v_pc;
  assign if0.in_reg     = v_reg;     assign if1.in_reg     = v_reg;
  assign if0.in_addr    = v_addr;    assign if1.in_addr    = v_addr;
  assign if0.in_data    = v_data;    assign if1.in_data    = v_data;
  assign if0.char_ready = cr;        assign if1.char_ready = cr;

  logic       cv, fd, rdy;
  logic [7:0] co;
  assign cv  = sel ? if1.char_valid : if0.char_valid;
  assign fd  = sel ? if1.frame_done : if0.frame_done;
  assign rdy = sel ? if1.in_ready   : if0.in_ready;
  assign co  = sel ? if1.char_out   : if0.char_out;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
    end
  endtask

  function automatic string h(input logic [31:0] v);
    return $sformatf("%0h", v);
  endfunction

  task automatic start(input logic s, input logic is_mem, input logic [13:0] t,
                       input logic [31:0] pc, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    int n;
    @(negedge clk);
    sel = s; v_is_mem = is_mem; v_time = t; v_pc = pc; v_reg = r; v_addr = a; v_data = d;
    v_valid = 1'b1;
    n = 0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", h(rdy), "1");
    @(posedge clk);
    #1;
    if (!hold) v_valid = 1'b0;
  endtask

  // Samples at negedges; drives char_ready for the following edge.
  task automatic collect(input string tag, input string exp, input int stall_idx,
                         input int stall_len, input int abort_n);
    string      got = "";
    int         idx = 0, stalled = 0, cyc = 0;
    bit         busy_ok = 1'b1, fd_ok = 1'b1, hold_ok = 1'b1, done = 1'b0;
    logic [7:0] held = 8'h00;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cv) begin
        if (rdy) busy_ok = 1'b0;
        if (idx == stall_idx && stalled < stall_len) begin
          if (stalled == 0) held = co;
          else if (co !== held) hold_ok = 1'b0;
          cr = 1'b0;
          stalled++;
          #1 if (fd) fd_ok = 1'b0;
        end else if (abort_n >= 0 && idx == abort_n) begin
          cr = 1'b0;
          done = 1'b1;
        end else begin
          cr = 1'b1;
          got = $sformatf("%s%c", got, co);
          #1;
          if (co == 8'h23) begin
            if (!fd) fd_ok = 1'b0;
            done = 1'b1;
          end else if (fd) fd_ok = 1'b0;
          idx++;
        end
      end else begin
        cr = 1'b1;
        #1 if (fd) fd_ok = 1'b0;
      end
    end
    if (abort_n < 0) begin
      check({tag, "_text"}, got, exp);
      check({tag, "_cycles"}, $sformatf("%0d", cyc), $sformatf("%0d", exp.len() + stall_len));
      check({tag, "_ready_low"}, h(busy_ok), "1");
      check({tag, "_frame_done"}, h(fd_ok), "1");
    end else begin
      check({tag, "_partial"}, got, exp);
    end
    if (stall_len > 0) check({tag, "_held"}, h(hold_ok), "1");
    if (abort_n < 0) cr = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_char_out",   h(co),  "0");
    check("rst_char_valid", h(cv),  "0");
    check("rst_frame_done", h(fd),  "0");
    check("rst_in_ready",   h(rdy), "1");

    // Basic register and memory frames, including clamp and zero/limit values.
    start(1'b0, 1'b0, 14'd5, 32'h0000_3000, 5'd2, 32'h0, 32'h0000_000a, 1'b0);
    collect("reg1", "^5@00003000: $2 <= 0000000a#", -1, 0, -1);
    start(1'b0, 1'b1, 14'd12345, 32'hdead_beef, 5'd0, 32'h1234_abcd, 32'h0, 1'b0);
    collect("mem_clamp", "^9999@deadbeef: *1234abcd <= 00000000#", -1, 0, -1);
    start(1'b0, 1'b0, 14'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    collect("zeros", "^0@00000000: $0 <= 00000000#", -1, 0, -1);
    start(1'b0, 1'b0, 14'd1234, 32'h0123_4567, 5'd31, 32'h0, 32'h89ab_cdef, 1'b0);
    collect("r31", "^1234@01234567: $31 <= 89abcdef#", -1, 0, -1);
    start(1'b0, 1'b0, 14'd100, 32'hffff_ffff, 5'd10, 32'h0, 32'h0000_0001, 1'b0);
    collect("t100", "^100@ffffffff: $10 <= 00000001#", -1, 0, -1);

    // Backpressure on the 4th char.
    start(1'b0, 1'b0, 14'd42, 32'h0000_0010, 5'd7, 32'h0, 32'h0000_beef, 1'b0);
    collect("stall", "^42@00000010: $7 <= 0000beef#", 3, 3, -1);

    // Back-to-back with in_valid held; fields change while frame A is in flight.
    start(1'b0, 1'b1, 14'd3, 32'h0000_0100, 5'd0, 32'h0000_0200, 32'h0000_0300, 1'b1);
    v_is_mem = 1'b0; v_time = 14'd9; v_pc = 32'hcafe_f00d; v_reg = 5'd5;
    v_addr = 32'hffff_0000; v_data = 32'h1111_1111;
    collect("b2b_a", "^3@00000100: *00000200 <= 00000300#", -1, 0, -1);
    @(negedge clk);
    check("b2b_gap_ready", h(rdy), "1");
    check("b2b_gap_valid", h(cv),  "0");
    @(posedge clk);
    #1 v_valid = 1'b0;
    collect("b2b_b", "^9@cafef00d: $5 <= 11111111#", -1, 0, -1);

    // Reset while the PC field is being sent.
    start(1'b0, 1'b0, 14'd5, 32'h0000_3000, 5'd2, 32'h0, 32'h0000_000a, 1'b0);
    collect("abort", "^5@000", -1, 0, 6);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_char_valid", h(cv),  "0");
    check("abort_in_ready",   h(rdy), "1");
    check("abort_frame_done", h(fd),  "0");
    check("abort_char_out",   h(co),  "0");
    cr = 1'b1;
    start(1'b0, 1'b0, 14'd5, 32'h0000_3000, 5'd2, 32'h0, 32'h0000_000a, 1'b0);
    collect("post_reset", "^5@00003000: $2 <= 0000000a#", -1, 0, -1);

    // Uppercase hex, spaces omitted.
    start(1'b1, 1'b1, 14'd77, 32'hdead_beef, 5'd0, 32'h0000_abcd, 32'hdead_beef, 1'b0);
    collect("upper", "^77@DEADBEEF:*0000ABCD<=DEADBEEF#", -1, 0, -1);
    start(1'b1, 1'b0, 14'd9999, 32'h00c0_ffee, 5'd19, 32'h0, 32'h0000_00fa, 1'b0);
    collect("upper_reg", "^9999@00C0FFEE:$19<=000000FA#", 3, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
